// File: rtl/fios_pkg.sv
// Shared types and constants for the FIOS Montgomery multiplier controller.
// Holds FSM states, DSP OPMODE words and PE operand-select encodings.
package fios_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fios_state_t;

    localparam logic [8:0] OPM_ZERO = 9'h000;
    localparam logic [8:0] OPM_M    = 9'h005;
    localparam logic [8:0] OPM_MC   = 9'h185;
    localparam logic [8:0] OPM_MP   = 9'h055;
    localparam logic [8:0] OPM_MCP  = 9'h1D5;

    // A/B selects: operand words, reduction (m, p'0), result feedback, parked
    localparam logic [1:0] SEL_OPND  = 2'd0;
    localparam logic [1:0] SEL_MOD   = 2'd1;
    localparam logic [1:0] SEL_RES   = 2'd2;
    localparam logic [1:0] SEL_OFF   = 2'd3;
    localparam logic [1:0] SEL_C_ACC = 2'd1;

    function automatic int fios_iter_len(input int abreg, input int mreg);
        return 2 * (1 + abreg + mreg) + 3;
    endfunction

endpackage

// File: rtl/fios_phase_cnt.sv
// Phase (0..T-1) and iteration (0..S-1) counter pair with terminal flags.
// Latency: counts update on the edge after en; no backpressure, clr dominates en.
// Backpressure: none.
module fios_phase_cnt #(
    parameter int T  = 9,
    parameter int S  = 16,
    parameter int PW = $clog2(T),
    parameter int IW = $clog2(S)
) (
    input  logic          clock_i,
    input  logic          reset_n_i,
    input  logic          clr,
    input  logic          en,
    output logic [PW-1:0] ph,
    output logic [IW-1:0] i,
    output logic          ph_last,
    output logic          i_last
);

    assign ph_last = (ph == PW'(T - 1));
    assign i_last  = (i == IW'(S - 1));

    always_ff @(posedge clock_i) begin
        if (!reset_n_i || clr) begin
            ph <= '0;
            i  <= '0;
        end else if (en) begin
            if (ph_last) begin
                ph <= '0;
                i  <= i_last ? '0 : i + IW'(1);
            end else begin
                ph <= ph + PW'(1);
            end
        end
    end

endmodule

// File: rtl/fios_ctrl.sv
// FIOS Montgomery multiply sequencer driving PE 0 enables, selects and DSP OPMODE.
// Latency: done_o 1+S*T+S+L+1 cycles after start; all outputs registered one cycle behind phase.
// Backpressure: start_i ignored unless IDLE; FIOS_CTRL_ABORT_EN adds abort_i to cancel RUN/DRAIN.
module fios_ctrl
    import fios_pkg::*;
#(
    parameter int ABREG = 1,
    parameter int MREG  = 1,
    parameter int S     = 16
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    input  logic                 start_i,
`ifdef FIOS_CTRL_ABORT_EN
    input  logic                 abort_i,
`endif
    output logic                 busy_o,
    output logic                 done_o,
    output logic [$clog2(S)-1:0] a_idx_o,
    output logic                 a_reg_en_o,
    output logic                 m_reg_en_o,
    output logic                 CREG_en_o,
    output logic                 RES_delay_en_o,
    output logic [1:0]           mux_A_sel_o,
    output logic [1:0]           mux_B_sel_o,
    output logic [1:0]           mux_C_sel_o,
    output logic [8:0]           OPMODE_o
);

    localparam int L       = 1 + ABREG + MREG;
    localparam int T       = fios_iter_len(ABREG, MREG);
    localparam int PW      = $clog2(T);
    localparam int IW      = $clog2(S);
    localparam int DRAIN_N = S + L;
    localparam int DW      = $clog2(DRAIN_N);

    localparam logic [PW-1:0] PH_LOAD = PW'(0);
    localparam logic [PW-1:0] PH_MUL  = PW'(1);
    localparam logic [PW-1:0] PH_RED  = PW'(1 + L);
    localparam logic [PW-1:0] PH_MREG = PW'(1 + 2 * L);
    localparam logic [PW-1:0] PH_ACC  = PW'(2 + 2 * L);

    fios_state_t   state_q, state_d;
    logic [PW-1:0] ph;
    logic [IW-1:0] i;
    logic          ph_last, i_last;
    logic [DW-1:0] drain_q;
    logic          drain_last;
    logic          kill;

    logic          busy_d, done_d, a_reg_en_d, m_reg_en_d, creg_en_d, res_en_d;
    logic [IW-1:0] a_idx_d;
    logic [1:0]    sel_a_d, sel_b_d, sel_c_d;
    logic [8:0]    opmode_d;

    fios_phase_cnt #(.T(T), .S(S), .PW(PW), .IW(IW)) u_phase_cnt (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .clr       (state_q != ST_RUN),
        .en        (state_q == ST_RUN),
        .ph        (ph),
        .i         (i),
        .ph_last   (ph_last),
        .i_last    (i_last)
    );

`ifdef FIOS_CTRL_ABORT_EN
    assign kill = abort_i && (state_q == ST_RUN || state_q == ST_DRAIN);
`else
    assign kill = 1'b0;
`endif

    assign drain_last = (drain_q == DW'(DRAIN_N - 1));

    always_ff @(posedge clock_i) begin
        if (!reset_n_i || state_q != ST_DRAIN) begin
            drain_q <= '0;
        end else begin
            drain_q <= drain_q + DW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_RUN;
            ST_RUN:   if (ph_last && i_last) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (kill) begin
            state_d = ST_IDLE;
        end
    end

    // Selects park at SEL_OFF outside RUN and otherwise hold between programmed phases
    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_q == ST_DONE);
        a_reg_en_d = 1'b0;
        m_reg_en_d = 1'b0;
        creg_en_d  = 1'b0;
        res_en_d   = 1'b0;
        a_idx_d    = '0;
        sel_a_d    = SEL_OFF;
        sel_b_d    = SEL_OFF;
        sel_c_d    = SEL_OFF;
        opmode_d   = OPM_ZERO;
        if (state_q == ST_RUN && !kill) begin
            sel_a_d  = mux_A_sel_o;
            sel_b_d  = mux_B_sel_o;
            sel_c_d  = mux_C_sel_o;
            opmode_d = OPM_MP;
            if (ph == PH_LOAD) begin
                a_reg_en_d = 1'b1;
                a_idx_d    = i;
            end else if (ph == PH_MUL) begin
                sel_a_d = SEL_OPND;
                sel_b_d = SEL_OPND;
                if (i == '0) begin
                    opmode_d = OPM_M;
                end else begin
                    opmode_d  = OPM_MC;
                    sel_c_d   = SEL_C_ACC;
                    creg_en_d = 1'b1;
                end
            end else if (ph == PH_RED) begin
                sel_a_d  = SEL_MOD;
                sel_b_d  = SEL_MOD;
                opmode_d = OPM_M;
            end else if (ph == PH_MREG) begin
                m_reg_en_d = 1'b1;
            end else if (ph == PH_ACC) begin
                sel_a_d  = SEL_RES;
                sel_b_d  = SEL_RES;
                opmode_d = OPM_MCP;
                res_en_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q        <= ST_IDLE;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            a_idx_o        <= '0;
            a_reg_en_o     <= 1'b0;
            m_reg_en_o     <= 1'b0;
            CREG_en_o      <= 1'b0;
            RES_delay_en_o <= 1'b0;
            mux_A_sel_o    <= SEL_OFF;
            mux_B_sel_o    <= SEL_OFF;
            mux_C_sel_o    <= SEL_OFF;
            OPMODE_o       <= OPM_ZERO;
        end else begin
            state_q        <= state_d;
            busy_o         <= busy_d;
            done_o         <= done_d;
            a_idx_o        <= a_idx_d;
            a_reg_en_o     <= a_reg_en_d;
            m_reg_en_o     <= m_reg_en_d;
            CREG_en_o      <= creg_en_d;
            RES_delay_en_o <= res_en_d;
            mux_A_sel_o    <= sel_a_d;
            mux_B_sel_o    <= sel_b_d;
            mux_C_sel_o    <= sel_c_d;
            OPMODE_o       <= opmode_d;
        end
    end

endmodule

// File: tb/tb_fios_ctrl.sv
// Directed bench for fios_ctrl with S=4, ABREG=MREG=1 (L=3, T=9, latency 45).
// Abort scenarios are exercised only when FIOS_CTRL_ABORT_EN is defined.
module tb_fios_ctrl;

    localparam int NCAP = 55;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic       busy, done, a_reg_en, m_reg_en, creg_en, res_en;
    logic [1:0] a_idx, sel_a, sel_b, sel_c;
    logic [8:0] opm;

    int vecs = 0;
    int errs = 0;

    logic       t_busy [0:63];
    logic       t_done [0:63];
    logic       t_aen  [0:63];
    logic       t_men  [0:63];
    logic       t_creg [0:63];
    logic       t_res  [0:63];
    logic [1:0] t_aidx [0:63];
    logic [1:0] t_sela [0:63];
    logic [1:0] t_selb [0:63];
    logic [1:0] t_selc [0:63];
    logic [8:0] t_opm  [0:63];

    always #5 clk = ~clk;

    fios_ctrl #(.ABREG(1), .MREG(1), .S(4)) dut (
        .clock_i        (clk),
        .reset_n_i      (reset_n),
        .start_i        (start_i),
`ifdef FIOS_CTRL_ABORT_EN
        .abort_i        (abort_i),
`endif
        .busy_o         (busy),
        .done_o         (done),
        .a_idx_o        (a_idx),
        .a_reg_en_o     (a_reg_en),
        .m_reg_en_o     (m_reg_en),
        .CREG_en_o      (creg_en),
        .RES_delay_en_o (res_en),
        .mux_A_sel_o    (sel_a),
        .mux_B_sel_o    (sel_b),
        .mux_C_sel_o    (sel_c),
        .OPMODE_o       (opm)
    );

    // Start pulse in cycle 0; entry n holds outputs seen n cycles later.
    task automatic run_capture(input int x1, input int x2, input int rst_at, input int abort_at);
        @(negedge clk);
        start_i = 1'b1;
        for (int n = 1; n <= NCAP; n++) begin
            @(negedge clk);
            t_busy[n] = busy;   t_done[n] = done;   t_aen[n]  = a_reg_en;
            t_men[n]  = m_reg_en; t_creg[n] = creg_en; t_res[n] = res_en;
            t_aidx[n] = a_idx;  t_sela[n] = sel_a;  t_selb[n] = sel_b;
            t_selc[n] = sel_c;  t_opm[n]  = opm;
            start_i = (n == x1) || (n == x2);
            reset_n = !(n == rst_at);
            abort_i = (n == abort_at);
        end
        start_i = 1'b0;
        reset_n = 1'b1;
        abort_i = 1'b0;
    endtask

    function automatic int first_done();
        for (int n = 1; n <= NCAP; n++) if (t_done[n]) return n;
        return -1;
    endfunction

    function automatic int done_count();
        int c = 0;
        for (int n = 1; n <= NCAP; n++) if (t_done[n]) c++;
        return c;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        vecs++;
        if ({busy, done} !== 2'b00) begin
            errs++; $display("FAIL reset_busy_done got=%b want=00", {busy, done});
        end
        vecs++;
        if ({a_reg_en, m_reg_en, creg_en, res_en} !== 4'b0000) begin
            errs++; $display("FAIL reset_enables got=%b want=0000", {a_reg_en, m_reg_en, creg_en, res_en});
        end
        vecs++;
        if ({sel_a, sel_b, sel_c} !== 6'b111111 || opm !== 9'h000 || a_idx !== 2'd0) begin
            errs++; $display("FAIL reset_sel_opm sel=%b opm=%h idx=%0d want sel=111111 opm=000 idx=0",
                             {sel_a, sel_b, sel_c}, opm, a_idx);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        run_capture(0, 0, 0, 0);
        vecs++;
        if (t_busy[1] !== 1'b1) begin errs++; $display("FAIL busy_after_start got=%b want=1", t_busy[1]); end
        vecs++;
        if (first_done() != 45) begin errs++; $display("FAIL done_latency got=%0d want=45", first_done()); end
        vecs++;
        if (done_count() != 1) begin errs++; $display("FAIL done_pulse_count got=%0d want=1", done_count()); end
        vecs++;
        if (t_busy[44] !== 1'b1 || t_busy[46] !== 1'b0) begin
            errs++; $display("FAIL busy_window got c44=%b c46=%b want 1,0", t_busy[44], t_busy[46]);
        end
    endtask

    task automatic test_enables();
        int ac = 0, mc = 0;
        for (int n = 1; n <= NCAP; n++) begin
            if (t_aen[n]) ac++;
            if (t_men[n]) mc++;
        end
        vecs++;
        if (ac != 4 || mc != 4) begin errs++; $display("FAIL enable_counts got a=%0d m=%0d want 4,4", ac, mc); end
        for (int k = 0; k < 4; k++) begin
            vecs++;
            if (t_aen[2 + 9 * k] !== 1'b1 || t_aidx[2 + 9 * k] !== 2'(k)) begin
                errs++; $display("FAIL a_load_%0d got en=%b idx=%0d want en=1 idx=%0d",
                                 k, t_aen[2 + 9 * k], t_aidx[2 + 9 * k], k);
            end
            vecs++;
            if (t_men[9 + 9 * k] !== 1'b1) begin
                errs++; $display("FAIL m_load_%0d got=%b want=1 (ph 1+2L)", k, t_men[9 + 9 * k]);
            end
        end
    endtask

    task automatic test_opmode();
        vecs++;
        if (t_opm[3] !== 9'h005 || t_creg[3] !== 1'b0 || t_sela[3] !== 2'd0 || t_selc[3] !== 2'd3) begin
            errs++; $display("FAIL i0_ph1 got opm=%h creg=%b selA=%0d selC=%0d want 005,0,0,3",
                             t_opm[3], t_creg[3], t_sela[3], t_selc[3]);
        end
        vecs++;
        if (t_opm[12] !== 9'h185 || t_creg[12] !== 1'b1 || t_selc[12] !== 2'd1 || t_selb[12] !== 2'd0) begin
            errs++; $display("FAIL i1_ph1 got opm=%h creg=%b selC=%0d selB=%0d want 185,1,1,0",
                             t_opm[12], t_creg[12], t_selc[12], t_selb[12]);
        end
        vecs++;
        if (t_opm[6] !== 9'h005 || t_sela[6] !== 2'd1 || t_selb[6] !== 2'd1) begin
            errs++; $display("FAIL i0_reduce got opm=%h selA=%0d selB=%0d want 005,1,1", t_opm[6], t_sela[6], t_selb[6]);
        end
        vecs++;
        if (t_opm[10] !== 9'h1D5 || t_res[10] !== 1'b1 || t_sela[10] !== 2'd2) begin
            errs++; $display("FAIL i0_accum got opm=%h res=%b selA=%0d want 1D5,1,2", t_opm[10], t_res[10], t_sela[10]);
        end
        vecs++;
        if (t_opm[7] !== 9'h055 || t_sela[7] !== 2'd1 || t_res[7] !== 1'b0) begin
            errs++; $display("FAIL idle_phase_hold got opm=%h selA=%0d res=%b want 055,1,0", t_opm[7], t_sela[7], t_res[7]);
        end
        vecs++;
        if (t_opm[2] !== 9'h055 || t_sela[2] !== 2'd3 || t_sela[11] !== 2'd2) begin
            errs++; $display("FAIL ph0_hold got opm=%h selA c2=%0d c11=%0d want 055,3,2", t_opm[2], t_sela[2], t_sela[11]);
        end
        vecs++;
        if (t_opm[40] !== 9'h000 || t_sela[40] !== 2'd3 || t_busy[40] !== 1'b1) begin
            errs++; $display("FAIL drain_outputs got opm=%h selA=%0d busy=%b want 000,3,1", t_opm[40], t_sela[40], t_busy[40]);
        end
    endtask

    task automatic test_back_to_back();
        bit stray = 1'b0;
        run_capture(10, 44, 0, 0);
        vecs++;
        if (first_done() != 45 || done_count() != 1) begin
            errs++; $display("FAIL start_while_busy got first=%0d count=%0d want 45,1", first_done(), done_count());
        end
        for (int n = 45; n <= NCAP; n++) if (t_busy[n] !== 1'b0) stray = 1'b1;
        vecs++;
        if (stray) begin errs++; $display("FAIL start_in_done got busy_after_done=1 want 0"); end
    endtask

    task automatic test_reset_mid();
        run_capture(0, 0, 20, 0);
        vecs++;
        if (t_busy[21] !== 1'b0 || t_opm[21] !== 9'h000 || t_sela[21] !== 2'd3 || t_aen[21] !== 1'b0) begin
            errs++; $display("FAIL reset_mid_idle got busy=%b opm=%h selA=%0d aen=%b want 0,000,3,0",
                             t_busy[21], t_opm[21], t_sela[21], t_aen[21]);
        end
        vecs++;
        if (done_count() != 0) begin errs++; $display("FAIL reset_mid_no_done got=%0d want=0", done_count()); end
        run_capture(0, 0, 0, 0);
        vecs++;
        if (first_done() != 45) begin errs++; $display("FAIL restart_latency got=%0d want=45", first_done()); end
    endtask

`ifdef FIOS_CTRL_ABORT_EN
    task automatic test_abort();
        run_capture(0, 0, 0, 40);
        vecs++;
        if (t_busy[41] !== 1'b0 || done_count() != 0) begin
            errs++; $display("FAIL abort_drain got busy=%b dones=%0d want 0,0", t_busy[41], done_count());
        end
        run_capture(0, 0, 0, 12);
        vecs++;
        if (t_busy[13] !== 1'b0 || t_opm[13] !== 9'h000 || t_sela[13] !== 2'd3 || done_count() != 0) begin
            errs++; $display("FAIL abort_run got busy=%b opm=%h selA=%0d dones=%0d want 0,000,3,0",
                             t_busy[13], t_opm[13], t_sela[13], done_count());
        end
        run_capture(0, 0, 0, 0);
        vecs++;
        if (first_done() != 45) begin errs++; $display("FAIL abort_recover got=%0d want=45", first_done()); end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_enables();
        test_opmode();
        test_back_to_back();
        test_reset_mid();
`ifdef FIOS_CTRL_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
